// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Shares one line-wide memory port among NUM_PORTS cache ports. Only one
//   transaction is in flight at a time: IDLE picks a winner and latches its
//   request, BUSY presents it to memory until mmem_resp, and RESP returns the
//   captured line with a one-cycle completion pulse to the winning port.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   -> round-robin arbitration. The search starts at a pointer that
//                moves to (granted port + 1) mod NUM_PORTS on each completion.
//   undefined -> fixed priority. Port 0 has the highest priority and there is
//                no pointer.
//
// Handshake: a port raises req_read and/or req_write (both together means a
//   write) and holds it until its own req_resp bit pulses for one cycle.
//   req_rdata is valid only in that cycle. On the memory side, mmem_read or
//   mmem_write stays high with a stable address and data until a one-cycle
//   mmem_resp is seen. mmem_resp outside BUSY is ignored.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   req_read/req_write per-port request strobes [NUM_PORTS]
//   req_address        per-port address, port i at [i*ADDR_W +: ADDR_W]
//   req_wdata          per-port write line, port i at [i*LINE_W +: LINE_W]
//   req_rdata          shared read line (valid during RESP only)
//   req_resp           one-hot completion pulse
//   mmem_*             memory-side strobes, address, data and response
//   dbg_state          current FSM state (IDLE=0, BUSY=1, RESP=2)
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic                        mmem_read,
  output logic                        mmem_write,
  output logic [ADDR_W-1:0]           mmem_address,
  output logic [LINE_W-1:0]           mmem_wdata,
  input  logic [LINE_W-1:0]           mmem_rdata,
  input  logic                        mmem_resp,
  output logic [1:0]                  dbg_state
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   line_q, line_d;
`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

  logic [NUM_PORTS-1:0] pending;
  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand_idx;

  assign pending = req_read | req_write;

  // Winner selection. Only the IDLE state uses it.
  always_comb begin : arbitrate
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef MEM_ARB_RR_EN
      // Walk upward from the pointer. Wrap by subtraction so that NUM_PORTS
      // does not have to be a power of two.
      if (int'(ptr_q) + k >= NUM_PORTS) cand_idx = IDX_W'(int'(ptr_q) + k - NUM_PORTS);
      else                              cand_idx = IDX_W'(int'(ptr_q) + k);
`else
      cand_idx = IDX_W'(k);
`endif
      if (!grant_vld && pending[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
`ifdef MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          idx_d   = grant_idx;
          wr_d    = req_write[grant_idx];  // read+write together is served as a write
          addr_d  = req_address[grant_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[grant_idx*LINE_W +: LINE_W];
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mmem_resp) begin
          line_d  = mmem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
`ifdef MEM_ARB_RR_EN
        if (idx_q == IDX_W'(NUM_PORTS - 1)) ptr_d = '0;
        else                                ptr_d = idx_q + IDX_W'(1);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // The outputs decode from the state register. An asynchronous reset therefore
  // drops the memory strobes at once, without waiting for a clock edge.
  always_comb begin : outputs
    req_resp   = '0;
    req_rdata  = '0;
    mmem_read  = 1'b0;
    mmem_write = 1'b0;
    if (state_q == ST_BUSY) begin
      mmem_read  = !wr_q;
      mmem_write = wr_q;
    end
    if (state_q == ST_RESP) begin
      req_resp[idx_q] = 1'b1;
      req_rdata       = line_q;
    end
  end

  assign mmem_address = addr_q;
  assign mmem_wdata   = wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Testbench for mem_arbiter_rr with four ports and 64-bit lines.
// A transaction-level model predicts, for each grant, the winner, opcode,
// address and data from the pending set. It also predicts the completion pulse
// and the returned line. Each cycle is sampled on the falling edge.
module tb_mem_arbiter_rr;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NP-1:0]   req_read = '0;
  logic [NP-1:0]   req_write = '0;
  logic [NP*AW-1:0] req_address = '0;
  logic [NP*LW-1:0] req_wdata = '0;
  logic [LW-1:0]   req_rdata;
  logic [NP-1:0]   req_resp;
  logic            mmem_read;
  logic            mmem_write;
  logic [AW-1:0]   mmem_address;
  logic [LW-1:0]   mmem_wdata;
  logic [LW-1:0]   mmem_rdata = '0;
  logic            mmem_resp = 1'b0;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_resp(req_resp),
    .mmem_read(mmem_read), .mmem_write(mmem_write),
    .mmem_address(mmem_address), .mmem_wdata(mmem_wdata),
    .mmem_rdata(mmem_rdata), .mmem_resp(mmem_resp),
    .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester state: op 0=read, 1=write, 2=read+write.
  logic [NP-1:0] active = '0;
  int            op[NP];
  logic [AW-1:0] addr[NP];
  logic [LW-1:0] wdata[NP];

  // Scoreboard and model state.
  logic [LW-1:0] exp_q[$];
  int            grant_log[$];
  int            start_cyc[$];
  int            cyc = 0, rr_ptr = 0, cur_port = 0, cur_lat = 0, lat_cnt = 0;
  int            win_len = 0, forced_lat = -1;
  bit            txn_active = 0, in_busy = 0, resp_due = 0, grant_due = 0;
  bit            release_next = 0, rand_en = 0, hold_all = 0, use_forced_data = 0;
  logic          cur_wr = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [LW-1:0] cur_wdata = '0;
  logic [LW-1:0] forced_data = '0;
  logic [NP-1:0] snap_pend = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration, taken directly from the selection rule.
  function automatic int ref_winner(input logic [NP-1:0] pend);
    int w;
    w = -1;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < NP; k++)
      if (w < 0 && pend[(rr_ptr + k) % NP]) w = (rr_ptr + k) % NP;
`else
    for (int k = 0; k < NP; k++)
      if (w < 0 && pend[k]) w = k;
`endif
    if (w < 0) w = 0;
    return w;
  endfunction

  task automatic new_req(input int p, input int o, input logic [AW-1:0] a, input logic [LW-1:0] d);
    active[p] = 1'b1;
    op[p]     = o;
    addr[p]   = a;
    wdata[p]  = d;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NP; i++) begin
      req_read[i]  = active[i] && op[i] != 1;
      req_write[i] = active[i] && op[i] != 0;
      req_address[i*AW +: AW] = addr[i];
      req_wdata[i*LW +: LW]   = wdata[i];
    end
    if (grant_due) snap_pend = active;
    else if (!txn_active && active != '0) begin
      grant_due  = 1;
      txn_active = 1;
      snap_pend  = active;
    end
  endtask

  task automatic model_clear();
    txn_active = 0; in_busy = 0; resp_due = 0; grant_due = 0; release_next = 0;
    exp_q.delete();
    rr_ptr    = 0;
    mmem_resp = 1'b0;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_rd"},    mmem_read, 1'b0);
    check({pfx, "_wr"},    mmem_write, 1'b0);
    check({pfx, "_addr"},  mmem_address, '0);
    check({pfx, "_wdata"}, mmem_wdata, '0);
    check({pfx, "_resp"},  req_resp, '0);
    check({pfx, "_rdata"}, req_rdata, '0);
    check({pfx, "_state"}, dbg_state, 2'd0);
  endtask

  // Call this right after a falling edge. It asserts reset between clock
  // edges, holds it across one rising edge and releases it after a falling edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 check_quiet("rst_async");
    model_clear();
    @(negedge clk);
    check_quiet("rst_held");
    #1 rst = 1'b1;
    #1 check("rst_no_early_grant", mmem_read | mmem_write, 1'b0);
    drive_req();
  endtask

  task automatic cycle();
    logic          strobe;
    logic [NP-1:0] onehot;
    int            w;
    @(negedge clk);
    cyc++;
    if (release_next) begin txn_active = 0; release_next = 0; end
    strobe = mmem_read | mmem_write;
    if (resp_due) begin
      onehot = '0;
      onehot[cur_port] = 1'b1;
      check("resp_onehot", req_resp, onehot);
      check("resp_rdata", req_rdata, exp_q.pop_front());
      check("busy_cycles", win_len, cur_lat + 1);
      if (!hold_all) active[cur_port] = 1'b0;
      rr_ptr = (cur_port + 1) % NP;
      resp_due = 0;
      release_next = 1;
    end else begin
      check("resp_quiet", req_resp, '0);
    end
    if (grant_due) begin
      grant_due = 0;
      check("grant_start", strobe, 1'b1);
      w = ref_winner(snap_pend);
      cur_port  = w;
      cur_wr    = (op[w] != 0);
      cur_addr  = addr[w];
      cur_wdata = wdata[w];
      check("grant_write", mmem_write, cur_wr);
      check("grant_read", mmem_read, !cur_wr);
      check("grant_addr", mmem_address, cur_addr);
      check("grant_wdata", mmem_wdata, cur_wdata);
      grant_log.push_back(w);
      start_cyc.push_back(cyc);
      cur_lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
      lat_cnt = cur_lat;
      win_len = 1;
      in_busy = 1;
    end else if (in_busy) begin
      win_len++;
      check("hold_write", mmem_write, cur_wr);
      check("hold_read", mmem_read, !cur_wr);
      check("hold_addr", mmem_address, cur_addr);
      check("hold_wdata", mmem_wdata, cur_wdata);
    end else begin
      check("strobe_quiet", strobe, 1'b0);
    end
    // Memory model. When not busy it sometimes sends a stray response, which must be ignored.
    mmem_resp = 1'b0;
    if (in_busy) begin
      if (lat_cnt == 0) begin
        mmem_rdata = use_forced_data ? forced_data : {$urandom, $urandom};
        mmem_resp  = 1'b1;
        exp_q.push_back(mmem_rdata);
        in_busy  = 0;
        resp_due = 1;
      end else lat_cnt--;
    end else if (rand_en && $urandom_range(0, 5) == 0) begin
      mmem_rdata = {$urandom, $urandom};
      mmem_resp  = 1'b1;
    end
    if (rand_en) begin
      for (int i = 0; i < NP; i++) begin
        if (!active[i] && $urandom_range(0, 2) == 0)
          new_req(i, int'($urandom_range(0, 2)), $urandom, {$urandom, $urandom});
        else if (active[i] && $urandom_range(0, 7) == 0) begin
          addr[i]  = $urandom;
          wdata[i] = {$urandom, $urandom};
        end
      end
    end
    drive_req();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_en = 0;
    while ((txn_active || release_next || active != '0) && n < 300) begin
      cycle();
      n++;
    end
    check("drain_done", txn_active || (active != '0), 1'b0);
    forced_lat = -1;
    use_forced_data = 0;
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!in_busy && n < 50) begin cycle(); n++; end
    check("busy_reached", in_busy, 1'b1);
  endtask

  task automatic collect(input int k);
    int n;
    n = 0;
    while (grant_log.size() < k && n < 200) begin cycle(); n++; end
    check("grants_seen", grant_log.size(), k);
  endtask

  initial begin
    int e;
    for (int i = 0; i < NP; i++) begin
      op[i] = 0;
      addr[i] = $urandom;
      wdata[i] = {$urandom, $urandom};
    end
    @(negedge clk);

    // Ports 0 and 1 pending continuously from reset.
    new_req(0, 0, $urandom, {$urandom, $urandom});
    new_req(1, 0, $urandom, {$urandom, $urandom});
    hold_all = 1;
    grant_log.delete();
    do_reset();
    collect(4);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      e = k % 2;
`else
      e = 0;
`endif
      check("order_2port", grant_log[k], e);
    end
    hold_all = 0;
    drain();

    // Single read on port 1 at 0x1040, with four BUSY cycles.
    new_req(1, 0, 32'h0000_1040, '0);
    forced_lat = 3;
    use_forced_data = 1;
    forced_data = {8{8'hA5}};
    drive_req();
    drain();

    // Read and write together on port 1 is served as a write.
    new_req(1, 2, 32'h0000_2000, {8{8'h5A}});
    forced_lat = 1;
    drive_req();
    drain();

    // Port 0 moves its address while its request is in flight.
    new_req(0, 0, 32'h0000_0100, {$urandom, $urandom});
    forced_lat = 3;
    drive_req();
    wait_busy();
    addr[0] = 32'h0000_0200;
    drive_req();
    drain();

    // Random traffic with latency jitter, address churn and stray responses.
    rand_en = 1;
    repeat (1500) cycle();
    drain();

    // Reset in the second BUSY cycle, after a completion on port 0.
    new_req(0, 0, 32'h0000_0300, {$urandom, $urandom});
    forced_lat = 0;
    drive_req();
    drain();
    new_req(1, 0, 32'h0000_0400, {$urandom, $urandom});
    forced_lat = 3;
    drive_req();
    wait_busy();
    cycle();
    new_req(0, 0, 32'h0000_0500, {$urandom, $urandom});
    grant_log.delete();
    do_reset();
    drain();
    check("rst_regrant_first", grant_log[0], 0);
    check("rst_regrant_second", grant_log[1], 1);

    // All four ports pending with immediate memory responses.
    for (int i = 0; i < NP; i++) new_req(i, 0, $urandom, {$urandom, $urandom});
    hold_all = 1;
    forced_lat = 0;
    grant_log.delete();
    start_cyc.delete();
    do_reset();
    collect(5);
    for (int k = 0; k < 5; k++) begin
`ifdef MEM_ARB_RR_EN
      e = k % NP;
`else
      e = 0;
`endif
      check("order_4port", grant_log[k], e);
    end
    for (int k = 0; k < 4; k++)
      check("turnaround", start_cyc[k+1] - start_cyc[k], 3);
    hold_all = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
